adc_frame_packer: RTL and testbench
===================================

// Module: adc_frame_packer
// PURPOSE
//  Upstream stage of the 4x64 PISO output shift register in the ADC acquisition path.
//  Packs the ADC sample stream into frames of WORDS x WORD_W bits.
//  Presents each complete frame on DOUT with a one-cycle LOAD pulse.
//  Enforces a minimum LOAD spacing so the downstream shifter can finish a frame
//  before the next one arrives. Buffers one complete frame and counts dropped frames.
// PARAMETERS
//  SAMPLE_W  16  ADC sample width; WORD_W must be an integer multiple of SAMPLE_W
//  WORD_W    64  packed word width (matches PISO word)
//  WORDS     4   words per frame (matches PISO depth)
//  HOLDOFF   4   minimum cycles between LOAD rising edges; must be >= 1
// PORTS
//  CLK           in   1         single clock, all logic on rising edge
//  RST           in   1         synchronous reset, active-high
//  SAMPLE_VALID  in   1         SAMPLE_DATA is valid this cycle; accepted unconditionally
//  SAMPLE_DATA   in   SAMPLE_W  ADC sample
//  SYNC          in   1         realign: discard partial frame; sample this cycle becomes sample 0
//  OVF_CLR       in   1         clears OVERFLOW and DROP_CNT
//  DOUT          out  WORD_W x [WORDS-1:0]  unpacked array, frame to PISO DIN
//  LOAD          out  1         one-cycle pulse; DOUT valid and stable while high, and held until next LOAD
//  PENDING       out  1         a complete frame is staged and waiting for holdoff
//  OVERFLOW      out  1         sticky: a frame was dropped
//  DROP_CNT      out  8         dropped-frame count, saturates at 255
// BEHAVIOUR
//  Reset (RST=1 at an edge): all outputs 0. DOUT all zero. Counters, assembly buffer,
//   staging buffer, pending flag and holdoff counter all 0. Reset overrides every other
//   input, including mid-frame; the partial frame is discarded.
//  Packing, with SPW = WORD_W/SAMPLE_W (4):
//   - sample k of word w goes to bits [SAMPLE_W*k +: SAMPLE_W].
//   - first sample of the frame -> word 0, bits [15:0]; last sample -> word WORDS-1, top slice.
//   - sample_cnt counts 0..SPW-1 and word_cnt counts 0..WORDS-1, both advancing on accepted samples only.
//  Frame complete: the edge accepting sample SPW*WORDS-1 (the 16th) performs:
//   - staging <= assembled frame, including that sample; pending <= 1;
//   - counters wrap to 0; the assembly buffer continues with no bubble.
//  Transfer, at an edge where pending=1 and hold_cnt=0:
//   - DOUT <= staging; LOAD <= 1 for exactly one cycle;
//   - hold_cnt <= HOLDOFF-1; pending <= 0, unless a frame completes at the same edge.
//  hold_cnt decrements by 1 per cycle while nonzero.
//  Latency: with hold_cnt=0, LOAD is high in the cycle following the edge one clock after
//   the final-sample edge, i.e. 2 edges after the last sample.
//  State (pending flag): EMPTY -> PEND on frame complete.
//   - PEND -> EMPTY on transfer.
//   - PEND stays PEND on transfer with a simultaneous completion: staging is reloaded
//     while the old staging value goes to DOUT.
//  Overflow: a frame completes while pending=1 and no transfer occurs at that edge.
//   - The new frame is dropped; staging keeps the older frame.
//   - OVERFLOW <= 1; DROP_CNT increments (saturating).
//   - OVF_CLR and a new drop at the same edge: the drop wins (OVERFLOW=1, DROP_CNT=1).
//  SYNC=1 at an edge:
//   - word_cnt and sample_cnt reset; the assembly buffer is cleared.
//   - If SAMPLE_VALID is also high, that sample is stored as sample 0 of the new frame and counters become 1.
//   - Staging, pending, DOUT and hold_cnt are unaffected. SYNC never causes a completion or a drop.
//  Back-to-back samples at full rate give one frame per 16 cycles.
//   - Requires HOLDOFF <= 16 for lossless operation; a larger HOLDOFF at full rate drops frames.
// TESTING
//  1 Reset: RST high 3 cycles with SAMPLE_VALID toggling -> DOUT all 0; LOAD, PENDING, OVERFLOW = 0; DROP_CNT=0.
//  2 Single frame: samples 16'h0001..16'h0010 back-to-back -> LOAD high 1 cycle, 2 edges after sample 16.
//    DOUT[0]=64'h0004_0003_0002_0001, DOUT[3]=64'h0010_000F_000E_000D.
//  3 Stream, HOLDOFF=4: 48 samples back-to-back -> 3 LOAD pulses spaced exactly 16 cycles apart; OVERFLOW stays 0.
//  4 Overflow, HOLDOFF=40: 48 samples back-to-back.
//    -> frame 2 PENDING, frame 3 dropped; OVERFLOW=1, DROP_CNT=1.
//    -> second LOAD at 40 cycles carries frame 2 (DOUT[0]=64'h0014_0013_0012_0011).
//    -> OVF_CLR then clears both.
//  5 SYNC: 5 samples, then SYNC together with SAMPLE_DATA=16'hAAAA, then 15 more samples
//    -> exactly one LOAD, with DOUT[0][15:0]=16'hAAAA.
//  6 Mid-frame reset: 10 samples, RST 1 cycle, 16 new samples -> single LOAD containing only the post-reset samples.

Source files
------------

// File: rtl/adc_frame_packer.sv
// Packs the ADC sample stream into WORDS x WORD_W frames and hands each complete
// frame to the PISO shifter with a LOAD pulse, spaced at least HOLDOFF cycles apart.
module adc_frame_packer #(
    parameter int SAMPLE_W = 16,
    parameter int WORD_W   = 64,
    parameter int WORDS    = 4,
    parameter int HOLDOFF  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sync,
    input  logic                ovf_clr,
    output logic [WORD_W-1:0]   dout [WORDS-1:0],
    output logic                load,
    output logic                pending,
    output logic                overflow,
    output logic [7:0]          drop_cnt
);
    localparam int SPW = WORD_W / SAMPLE_W;
    localparam int SCW = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic {EMPTY, PEND} state_t;

    state_t            state;
    logic [SCW-1:0]    sample_cnt;
    logic [WCW-1:0]    word_cnt;
    logic [HCW-1:0]    hold_cnt;
    logic [WORD_W-1:0] asm_buf [WORDS-1:0];
    logic [WORD_W-1:0] staging [WORDS-1:0];

    logic [SCW-1:0]    base_s;
    logic [SCW-1:0]    next_s;
    logic [WCW-1:0]    base_w;
    logic [WCW-1:0]    next_w;
    logic [WORD_W-1:0] last_word;
    logic              complete;
    logic              transfer;
    logic              drop;

    // A sync restarts the frame, so a sample accepted with it lands at position zero.
    always_comb begin
        base_s = sync ? '0 : sample_cnt;
        base_w = sync ? '0 : word_cnt;
        next_s = base_s + 1'b1;
        next_w = base_w;
        if (base_s == SCW'(SPW - 1)) begin
            next_s = '0;
            next_w = (base_w == WCW'(WORDS - 1)) ? '0 : base_w + 1'b1;
        end
        complete  = sample_valid && !sync &&
                    (sample_cnt == SCW'(SPW - 1)) && (word_cnt == WCW'(WORDS - 1));
        transfer  = (state == PEND) && (hold_cnt == '0);
        drop      = complete && (state == PEND) && !transfer;
        last_word = asm_buf[WORDS-1];
        last_word[SAMPLE_W*(SPW-1) +: SAMPLE_W] = sample_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            sample_cnt <= '0;
            word_cnt   <= '0;
            hold_cnt   <= '0;
            load       <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            for (int w = 0; w < WORDS; w++) begin
                asm_buf[w] <= '0;
                staging[w] <= '0;
                dout[w]    <= '0;
            end
        end else begin
            load <= transfer;

            if (sample_valid || sync) begin
                sample_cnt <= sample_valid ? next_s : '0;
                word_cnt   <= sample_valid ? next_w : '0;
            end
            if (sync) begin
                for (int w = 0; w < WORDS; w++) asm_buf[w] <= '0;
            end
            if (sample_valid) asm_buf[base_w][SAMPLE_W*base_s +: SAMPLE_W] <= sample_data;

            if (transfer) begin
                for (int w = 0; w < WORDS; w++) dout[w] <= staging[w];
                hold_cnt <= HCW'(HOLDOFF - 1);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            // The outgoing frame is read from staging before a same-edge completion refills it.
            if (complete && !drop) begin
                for (int w = 0; w < WORDS; w++)
                    staging[w] <= (w == WORDS - 1) ? last_word : asm_buf[w];
                state <= PEND;
            end else if (transfer) begin
                state <= EMPTY;
            end

            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= ovf_clr ? 8'd1 : ((drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 1'b1);
            end else if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    assign pending = (state == PEND);
endmodule

// File: tb/tb_adc_frame_packer.sv
// Drives two packers (HOLDOFF 4 and 40) with the same stream; a frame-level model
// predicts LOAD events into queues that a negedge monitor pops and compares.
module tb_adc_frame_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        sync;
    logic        ovf_clr;

    logic [63:0] dout_a [3:0];
    logic [63:0] dout_b [3:0];
    logic        load_a, pending_a, overflow_a;
    logic        load_b, pending_b, overflow_b;
    logic [7:0]  drop_a, drop_b;

    always #5 clk = ~clk;

    adc_frame_packer #(.SAMPLE_W(16), .WORD_W(64), .WORDS(4), .HOLDOFF(4)) dut_a (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .sync(sync), .ovf_clr(ovf_clr), .dout(dout_a), .load(load_a),
        .pending(pending_a), .overflow(overflow_a), .drop_cnt(drop_a)
    );

    adc_frame_packer #(.SAMPLE_W(16), .WORD_W(64), .WORDS(4), .HOLDOFF(40)) dut_b (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .sync(sync), .ovf_clr(ovf_clr), .dout(dout_b), .load(load_b),
        .pending(pending_b), .overflow(overflow_b), .drop_cnt(drop_b)
    );

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    bit model_valid = 0;

    // Frames are kept flat: sample n of the frame lives at bits [16n +: 16].
    logic [255:0] m_asm [2];
    logic [255:0] m_stg [2];
    logic [255:0] m_dout [2];
    int m_n [2];
    int m_hold [2];
    int m_drop [2];
    bit m_pend [2];
    bit m_ovf [2];
    int hoff [2] = '{4, 40};

    int qa_e[$];
    int qb_e[$];
    logic [255:0] qa_f[$];
    logic [255:0] qb_f[$];
    int la[$];
    int lb[$];
    logic [255:0] last_a = '0;
    logic [255:0] last_b = '0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelStep(input int i);
        bit complete;
        bit xfer;
        bit dropped;
        logic [255:0] fr;
        if (rst) begin
            m_n[i] = 0; m_hold[i] = 0; m_drop[i] = 0;
            m_pend[i] = 0; m_ovf[i] = 0;
            m_asm[i] = '0; m_stg[i] = '0; m_dout[i] = '0;
            return;
        end
        complete = 0;
        fr = '0;
        if (sync) begin
            m_asm[i] = '0;
            m_n[i] = 0;
        end
        if (sample_valid) begin
            m_asm[i][16*m_n[i] +: 16] = sample_data;
            m_n[i]++;
            if (m_n[i] == 16) begin
                complete = 1;
                fr = m_asm[i];
                m_n[i] = 0;
            end
        end
        xfer = m_pend[i] && (m_hold[i] == 0);
        dropped = complete && m_pend[i] && !xfer;
        if (xfer) begin
            m_dout[i] = m_stg[i];
            if (i == 0) begin qa_e.push_back(edge_no); qa_f.push_back(m_stg[i]); end
            else        begin qb_e.push_back(edge_no); qb_f.push_back(m_stg[i]); end
            m_hold[i] = hoff[i] - 1;
        end else if (m_hold[i] > 0) begin
            m_hold[i]--;
        end
        if (complete && !dropped) begin
            m_stg[i] = fr;
            m_pend[i] = 1;
        end else if (xfer) begin
            m_pend[i] = 0;
        end
        if (dropped) begin
            m_ovf[i] = 1;
            m_drop[i] = ovf_clr ? 1 : ((m_drop[i] >= 255) ? 255 : m_drop[i] + 1);
        end else if (ovf_clr) begin
            m_ovf[i] = 0;
            m_drop[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        edge_no++;
        for (int i = 0; i < 2; i++) modelStep(i);
        if (rst) model_valid = 1;
    end

    function automatic int peekEdge(input int i);
        if (i == 0) return (qa_e.size() > 0) ? qa_e[0] : -1;
        return (qb_e.size() > 0) ? qb_e[0] : -1;
    endfunction

    task automatic popExp(input int i, output bit have, output int e, output logic [255:0] f);
        have = 0; e = 0; f = '0;
        if (i == 0 && qa_e.size() > 0) begin have = 1; e = qa_e.pop_front(); f = qa_f.pop_front(); end
        if (i == 1 && qb_e.size() > 0) begin have = 1; e = qb_e.pop_front(); f = qb_f.pop_front(); end
    endtask

    task automatic monitorInst(input int i, input logic ld, input logic pd, input logic ov,
                               input logic [7:0] dc, input logic [255:0] d);
        string nm;
        bit have;
        int e;
        logic [255:0] f;
        nm = (i == 0) ? "A" : "B";
        if (ld) begin
            popExp(i, have, e, f);
            if (!have) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedLoad%s: got load at edge %0d expected none", nm, edge_no);
            end else begin
                checkOutput({"loadEdge", nm}, 256'(edge_no), 256'(e));
                checkOutput({"loadFrame", nm}, d, f);
            end
            if (i == 0) begin la.push_back(edge_no); last_a = d; end
            else        begin lb.push_back(edge_no); last_b = d; end
        end else if (peekEdge(i) >= 0 && peekEdge(i) <= edge_no) begin
            popExp(i, have, e, f);
            checks++;
            errors++;
            $display("[TB] FAIL missingLoad%s: got no load expected one at edge %0d", nm, e);
        end
        checkOutput({"pending", nm}, 256'(pd), 256'(m_pend[i]));
        checkOutput({"overflow", nm}, 256'(ov), 256'(m_ovf[i]));
        checkOutput({"dropCnt", nm}, 256'(dc), 256'(m_drop[i]));
        checkOutput({"doutHeld", nm}, d, m_dout[i]);
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            monitorInst(0, load_a, pending_a, overflow_a, drop_a,
                        {dout_a[3], dout_a[2], dout_a[1], dout_a[0]});
            monitorInst(1, load_b, pending_b, overflow_b, drop_b,
                        {dout_b[3], dout_b[2], dout_b[1], dout_b[0]});
        end
    end

    task automatic applyStimulus(input bit r, input bit v, input logic [15:0] d, input bit s, input bit c);
        @(negedge clk);
        rst = r; sample_valid = v; sample_data = d; sync = s; ovf_clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 16'h0, 0, 0);
    endtask

    task automatic clearLogs;
        la.delete();
        lb.delete();
    endtask

    initial begin
        int last_edge;
        rst = 1; sample_valid = 0; sample_data = '0; sync = 0; ovf_clr = 0;

        for (int k = 0; k < 3; k++) applyStimulus(1, k[0], 16'($urandom), 0, 0);
        idle(1);
        #1;
        checkOutput("rstDoutA", {dout_a[3], dout_a[2], dout_a[1], dout_a[0]}, '0);
        checkOutput("rstDoutB", {dout_b[3], dout_b[2], dout_b[1], dout_b[0]}, '0);
        checkOutput("rstFlagsA", {load_a, pending_a, overflow_a}, '0);
        checkOutput("rstFlagsB", {load_b, pending_b, overflow_b}, '0);
        checkOutput("rstDropA", drop_a, '0);
        checkOutput("rstDropB", drop_b, '0);

        clearLogs();
        for (int k = 1; k <= 16; k++) applyStimulus(0, 1, 16'(k), 0, 0);
        last_edge = edge_no + 1;
        idle(60);
        #1;
        checkOutput("singleCount", 256'(la.size()), 256'd1);
        checkOutput("singleLatency", 256'((la.size() > 0) ? la[0] : -1), 256'(last_edge + 1));
        checkOutput("singleWord0", last_a[63:0], 64'h0004_0003_0002_0001);
        checkOutput("singleWord3", last_a[255:192], 64'h0010_000F_000E_000D);

        clearLogs();
        for (int k = 1; k <= 48; k++) applyStimulus(0, 1, 16'(k), 0, 0);
        idle(80);
        #1;
        checkOutput("streamCount", 256'(la.size()), 256'd3);
        checkOutput("streamGap1", 256'((la.size() >= 2) ? la[1] - la[0] : -1), 256'd16);
        checkOutput("streamGap2", 256'((la.size() >= 3) ? la[2] - la[1] : -1), 256'd16);
        checkOutput("streamOvf", 256'(overflow_a), 256'd0);
        checkOutput("ovfCount", 256'(lb.size()), 256'd2);
        checkOutput("ovfGap", 256'((lb.size() >= 2) ? lb[1] - lb[0] : -1), 256'd40);
        checkOutput("ovfFrame2", last_b[63:0], 64'h0014_0013_0012_0011);
        checkOutput("ovfFlag", 256'(overflow_b), 256'd1);
        checkOutput("ovfDrop", 256'(drop_b), 256'd1);
        applyStimulus(0, 0, 16'h0, 0, 1);
        idle(2);
        #1;
        checkOutput("ovfClrFlag", 256'(overflow_b), 256'd0);
        checkOutput("ovfClrDrop", 256'(drop_b), 256'd0);

        clearLogs();
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 16'(16'h50 + k), 0, 0);
        applyStimulus(0, 1, 16'hAAAA, 1, 0);
        for (int k = 0; k < 15; k++) applyStimulus(0, 1, 16'(16'h60 + k), 0, 0);
        idle(30);
        #1;
        checkOutput("syncCountA", 256'(la.size()), 256'd1);
        checkOutput("syncCountB", 256'(lb.size()), 256'd1);
        checkOutput("syncSample0A", last_a[15:0], 16'hAAAA);
        checkOutput("syncSample1A", last_a[31:16], 16'h0060);
        checkOutput("syncSample0B", last_b[15:0], 16'hAAAA);

        clearLogs();
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, 16'(16'h0F0 + k), 0, 0);
        applyStimulus(1, 1, 16'hDEAD, 0, 0);
        for (int k = 0; k < 16; k++) applyStimulus(0, 1, 16'(16'h100 + k), 0, 0);
        idle(30);
        #1;
        checkOutput("midRstCount", 256'(la.size()), 256'd1);
        checkOutput("midRstWord0", last_a[63:0], 64'h0103_0102_0101_0100);
        checkOutput("midRstWord3", last_a[255:192], 64'h010F_010E_010D_010C);

        repeat (3000) begin
            applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                          16'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 49) == 0);
        end
        idle(60);
        #1;
        checkOutput("drainA", 256'(qa_e.size()), 256'd0);
        checkOutput("drainB", 256'(qb_e.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
